// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants, pointer-width helper and flag bundle for
//                the synchronous FIFO and its test environment monitor.
//                Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Simple dual-port storage array: one synchronous write port
//                and one registered read port. Array contents are never
//                reset; only the read register is.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Capture the addressed word on an accepted read; hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock parameterised FIFO with registered read data,
//                full/empty and threshold flags and an occupancy count.
//                Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow and
//                underflow outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW-1:0] c_one      = PW'(1);
    localparam logic [PW-1:0] c_af_level = PW'(AF_LEVEL);
    localparam logic [PW-1:0] c_ae_level = PW'(AE_LEVEL);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_rd_valid;
    fifo_flags_t   r_flags;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [PW-1:0] w_count_nxt;
    fifo_flags_t   w_flags_nxt;

    // Requests are dropped against the current registered flags, so a write
    // while full is lost even if a read is accepted on the same edge.
    assign w_wr_acc = wr_en && !r_flags.full;
    assign w_rd_acc = rd_en && !r_flags.empty;

    // Next pointer, count and flag state; flags derive from next state so
    // that all registered outputs agree with each other every cycle.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + c_one;
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + c_one;
        end
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_one;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - c_one;
        end
        w_flags_nxt.empty        = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_flags_nxt.full         = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                                   (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
        w_flags_nxt.almost_full  = (w_count_nxt >= c_af_level);
        w_flags_nxt.almost_empty = (w_count_nxt <= c_ae_level);
    end

    // Pointer, count, flag and read-valid registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_flags    <= '{full: 1'b0, almost_full: 1'b0, empty: 1'b1, almost_empty: 1'b1};
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_acc;
            r_flags    <= w_flags_nxt;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (rd_data)
    );

    assign full         = r_flags.full;
    assign almost_full  = r_flags.almost_full;
    assign empty        = r_flags.empty;
    assign almost_empty = r_flags.almost_empty;
    assign count        = r_count;
    assign rd_valid     = r_rd_valid;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky drop indicators, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_flags.full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && r_flags.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
        !(wr_en && r_flags.full)) else $error("sync_fifo: write dropped while full");
    a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
        !(rd_en && r_flags.empty)) else $error("sync_fifo: read dropped while empty");
`endif

endmodule : sync_fifo
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised synchronous FIFO. It is the device under test that the FIFO test environment drives. The write port is fed by the environment's write master and the read port is drained by its read master. It provides registered read data, full/empty and threshold flags, and an occupancy count.

## Interface
- DATA_W, 8, width of each stored word
- DEPTH, 16, number of entries; power of two, minimum 4
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- full  out  1  no free entries
- almost_full  out  1  count >= AF_LEVEL
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  rd_data holds a newly popped word this cycle
- empty  out  1  no stored entries
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; present only when the configuration macro is defined
- underflow  out  1  sticky; present only when the configuration macro is defined

## Operation
- Pointers: wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) and (wrap bits differ).
- A write is accepted when wr_en && !full. The word is stored at wr_ptr and wr_ptr increments.
- A write while full is dropped, even if a read is accepted in the same cycle. Storage and pointers are unchanged.
- A read is accepted when rd_en && !empty. rd_ptr increments.
- A read while empty is dropped, even if a write is accepted in the same cycle.
- count update per cycle:
  - +1 on a write-only accept.
  - -1 on a read-only accept.
  - Unchanged when both are accepted or neither is.
  - count never exceeds DEPTH and never goes below 0.
- Simultaneous accepted read and write at the same address cannot occur, because the FIFO is neither full nor empty in that case. No bypass path exists.
- Pointer wrap-around follows natural binary overflow of the pointer width.
- Reset, including assertion mid-operation, clears all state immediately:
  - Pointers, count and rd_valid go to 0.
  - rd_data goes to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - overflow=0 and underflow=0 when present.
  - Memory contents are not cleared.

## Timing
- Write-to-empty deassertion takes 1 cycle: empty falls on the edge that stores the first word.
- Read latency is 1 cycle. rd_data and rd_valid are registered on the edge that accepts rd_en. rd_valid is high for exactly one cycle per accepted read.
- When no read is accepted, rd_data holds its last value.
- All flags and count are registered and consistent with each other in every cycle. They reflect the state after the most recent edge.
- A full FIFO accepts a write one cycle after a read is accepted.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN
  - Defined: adds the overflow and underflow ports.
    - overflow sets on a dropped write (wr_en && full).
    - underflow sets on a dropped read (rd_en && empty).
    - Both stay set until reset.
    - With this macro and SVA enabled, assertions fire on each drop.
  - Undefined: the ports and logic are absent. Dropped requests remain silent.

## Structure
- Package fifo_pkg holds:
  - Default DATA_W and DEPTH constants.
  - A ptr_w(depth) function returning $clog2(depth)+1.
  - A fifo_flags_t packed struct {full, almost_full, empty, almost_empty}, shared with the test environment's monitor.
- One sub-module, fifo_mem: a simple dual-port array with one synchronous write port and a registered read port. It is parameterised by DATA_W and DEPTH.
- Pointer, flag and count logic live in sync_fifo.

## Test plan
- Reset then idle: empty=1, almost_empty=1, count=0, full=0, rd_valid=0 for 10 cycles.
- Fill: write 0x00..0x0F on consecutive cycles (DEPTH=16). Required response:
  - almost_full rises when count=14.
  - full=1 and count=16 after the 16th write.
  - A 17th write of 0xAA is dropped (overflow=1 with the macro).
- Drain: 16 consecutive reads return 0x00..0x0F in order, each one cycle after rd_en with rd_valid high. Then empty=1, count=0. A further read gives rd_valid=0 (underflow=1 with the macro).
- Wrap: repeat 8 writes followed by 8 reads, 5 times (40 words through 16 entries). Every word is read back in order and count returns to 0 each pass.
- Simultaneous read and write:
  - At count=5: count stays 5, and the oldest word is returned.
  - When full: the write is dropped, count becomes 15.
  - When empty: the read is dropped, count becomes 1.
- Mid-operation reset: pulse rstn low for 1 cycle at count=9 asynchronously to clk. Flags and count reset immediately. The next write/read pair returns the new word.
